// File: rtl/countdown_timer.sv
// countdown_timer: loadable, pausable prescaled down-counter with a sticky done flag.
// Define COUNTDOWN_AUTO_RELOAD_EN to reload from the last loaded value on expiry instead of stopping.
module countdown_timer #(
    parameter int WIDTH    = 32,
    parameter int PRESCALE = 100000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             pause,
    input  logic             ack,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             running,
    output logic             done
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d, reload_q, reload_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic             tick_q, tick_d, done_q, done_d;
    logic             tick_now;

    assign tick_now = (state_q == RUN) && (pre_q == PRE_MAX) && (count_q != '0);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        pre_d    = pre_q;
        done_d   = done_q;
        tick_d   = 1'b0;
        if (load) begin
            count_d  = load_value;
            reload_d = load_value;
            pre_d    = '0;
            done_d   = 1'b0;
            state_d  = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (count_q != '0) begin
                            state_d = RUN;
                            pre_d   = '0;
                        end else begin
                            state_d = EXPIRED;
                            done_d  = 1'b1;
                        end
                    end
                end
                RUN: begin
                    pre_d = pre_q + 1'b1;
                    if (ack) done_d = 1'b0;
                    if (tick_now) begin
                        pre_d   = '0;
                        tick_d  = 1'b1;
                        count_d = count_q - 1'b1;
                        if (count_q == WIDTH'(1)) begin
                            done_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                            if (reload_q != '0) count_d = reload_q;
                            else state_d = EXPIRED;
`else
                            state_d = EXPIRED;
`endif
                        end
                    end
                    // an expiry on the same edge outranks the pause request
                    if (pause && !ack && state_d == RUN) state_d = PAUSED;
                end
                PAUSED: begin
                    if (start && !ack && !pause) state_d = RUN;
                end
                EXPIRED: begin
                    if (ack) begin
                        state_d = IDLE;
                        done_d  = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            pre_q    <= '0;
            tick_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            pre_q    <= pre_d;
            tick_q   <= tick_d;
            done_q   <= done_d;
        end
    end

    assign count   = count_q;
    assign tick    = tick_q;
    assign done    = done_q;
    assign running = (state_q == RUN);
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: scoreboarded bench; expected ticks are queued at start and matched on each tick pulse.
module tb_countdown_timer;
    localparam int W = 8;
    localparam int P = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         load = 1'b0, start = 1'b0, pause = 1'b0, ack = 1'b0;
    logic [W-1:0] load_value = '0;
    logic [W-1:0] count;
    logic         tick, running, done;

    countdown_timer #(.WIDTH(W), .PRESCALE(P)) dut (
        .clk(clk), .reset_n(reset_n), .load(load), .load_value(load_value),
        .start(start), .pause(pause), .ack(ack),
        .count(count), .tick(tick), .running(running), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int           at;
        logic [W-1:0] cnt;
        logic         dn;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_ticks(input int e0, input int n0, input int first, input int period);
        for (int k = 0; k < n0; k++)
            sb.push_back('{at: e0 + first + k * period, cnt: W'(n0 - 1 - k), dn: (n0 - 1 - k) == 0});
    endtask

    task automatic pulse_load(input logic [W-1:0] v);
        load = 1'b1;
        load_value = v;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset_n && tick) begin
            if (sb.size() == 0) check("tick_unexpected", 1, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                check("tick_cycle", cyc, e.at);
                check("tick_count", count, e.cnt);
                check("tick_done", done, e.dn);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout checks %0d", checks);
        $fatal(1);
    end

    initial begin
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_count", count, 0);
        check("rst_done", done, 0);
        check("rst_running", running, 0);
        check("rst_tick", tick, 0);
        reset_n = 1'b1;
        @(negedge clk);

        pulse_load(3);
        check("load_count", count, 3);
        start = 1'b1;
        push_ticks(cyc + 1, 3, P, P);
        @(negedge clk);
        start = 1'b0;
        check("basic_running", running, 1);
        check("basic_count", count, 3);
        repeat (13) @(negedge clk);
        check("basic_drained", sb.size(), 0);
        check("basic_done", done, 1);
        check("basic_stopped", running, 0);
        pulse_ack();
        check("ack_done", done, 0);
        check("ack_running", running, 0);

        pulse_load(0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("zero_done", done, 1);
        check("zero_running", running, 0);
        check("zero_tick", tick, 0);
        pulse_ack();
        check("zero_ack", done, 0);

        pulse_load(5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
        check("pause_running", running, 0);
        repeat (8) @(negedge clk);
        check("pause_count", count, 5);
        check("pause_still", running, 0);
        start = 1'b1;
        push_ticks(cyc + 1, 5, 2, P);
        @(negedge clk);
        start = 1'b0;
        check("resume_running", running, 1);
        repeat (19) @(negedge clk);
        check("pause_drained", sb.size(), 0);
        check("pause_done", done, 1);
        pulse_ack();

        pulse_load(3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        load = 1'b1;
        load_value = 9;
        @(negedge clk);
        load = 1'b0;
        check("loadtick_count", count, 9);
        check("loadtick_tick", tick, 0);
        check("loadtick_running", running, 0);
        check("loadtick_done", done, 0);

        pulse_load(1);
        start = 1'b1;
        push_ticks(cyc + 1, 1, P, P);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
        check("lastpause_running", running, 0);
        check("lastpause_done", done, 1);
        check("lastpause_count", count, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("expired_start_ignored", running, 0);
        check("expired_done_held", done, 1);
        check("lastpause_drained", sb.size(), 0);
        pulse_ack();
        check("lastpause_ack", done, 0);

        pulse_load(3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_count", count, 0);
        check("async_rst_done", done, 0);
        check("async_rst_running", running, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
        begin
            int e0;
            pulse_load(2);
            start = 1'b1;
            e0 = cyc + 1;
            sb.push_back('{at: e0 + 4,  cnt: W'(1), dn: 1'b0});
            sb.push_back('{at: e0 + 8,  cnt: W'(2), dn: 1'b1});
            sb.push_back('{at: e0 + 12, cnt: W'(1), dn: 1'b0});
            sb.push_back('{at: e0 + 16, cnt: W'(2), dn: 1'b1});
            @(negedge clk);
            start = 1'b0;
            repeat (8) @(negedge clk);
            pulse_ack();
            check("auto_ack_done", done, 0);
            check("auto_ack_running", running, 1);
            repeat (8) @(negedge clk);
            check("auto_drained", sb.size(), 0);
            check("auto_running", running, 1);
            pulse_load(0);
            check("auto_stop", running, 0);
        end
`endif

        check("final_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable, pausable down-counter that decrements a `WIDTH`-bit value once every `PRESCALE` clock cycles and raises a sticky `done` flag on reaching zero. It is the counting-down counterpart of the up-counter primitives and drives game and round timers on the board. The front end feeds it debounced button pulses, and the display logic reads `count` directly.

## Interface
- `WIDTH`, 32: count width in bits (≥2).
- `PRESCALE`, 100000: clock cycles per decrement tick (≥1).

- `clk` input 1: single clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `load` input 1: load `load_value` into the counter (one-cycle pulse).
- `load_value` input WIDTH: value captured on `load`.
- `start` input 1: start from IDLE, or resume from PAUSED.
- `pause` input 1: freeze counting while RUN.
- `ack` input 1: clear `done` and leave EXPIRED.
- `count` output WIDTH: current remaining value (registered).
- `tick` output 1: one-cycle pulse on every decrement.
- `running` output 1: high while in RUN.
- `done` output 1: sticky expiry flag, held until `ack` or `load`.

## Operation
- States: IDLE, RUN, PAUSED, EXPIRED. Internal prescaler `pre`, range 0..PRESCALE-1.
- Reset (async, `reset_n`=0): state IDLE, `count`=0, `pre`=0, `tick`=0, `running`=0, `done`=0, reload register=0.
- Priority in every state: `load` > `ack` > `pause` > `start`.
- `load` in any state:
  - `count`←`load_value`, reload register←`load_value`.
  - `pre`←0, `done`←0, state←IDLE.
- IDLE:
  - `start` with `count`≠0 → RUN, `pre`←0.
  - `start` with `count`=0 → EXPIRED, `done`←1.
  - `pause` and `ack` are ignored.
- RUN:
  - `pre` increments each cycle.
  - When `pre`=PRESCALE-1: `pre`←0, `tick`←1, `count`←`count`-1.
  - If that decrement takes `count` from 1 to 0: state←EXPIRED, `done`←1.
  - `pause` → PAUSED with `pre` held. If a tick happens in the same cycle, the decrement still occurs; if it reaches zero, EXPIRED wins over PAUSED.
- PAUSED:
  - `count` and `pre` are frozen.
  - `start` → RUN and counting resumes from the held `pre`.
- EXPIRED:
  - `count`=0 and `done`=1 until `ack`.
  - `ack` → IDLE, `done`←0.
  - `start` is ignored.
- `count` never underflows. No decrement ever occurs from 0.
- Simultaneous `load` and a tick: the load wins and no tick pulse is emitted.

## Timing
- All outputs are registered and update on the clock edge after the input is sampled.
- With `start` sampled at edge E0, the first `tick` and decrement happen at edge E0+PRESCALE. Value N reaches 0 at edge E0+N·PRESCALE, and `done` rises on that same edge.
- `tick` is exactly one cycle wide. With PRESCALE=1 it is high every RUN cycle.
- `running` is high exactly during RUN.
- Time spent in PAUSED does not advance `pre`. The remaining fraction of the current period is preserved across a pause.
- `reset_n` deasserted mid-count aborts immediately to reset values. No partial tick is emitted.

## Configuration
- `COUNTDOWN_AUTO_RELOAD_EN` defined:
  - A decrement to 0 in RUN instead sets `count`←reload register and stays in RUN, with `pre`←0.
  - `done` is still set (sticky) and `tick` still pulses. `ack` clears `done` without changing state.
  - If the reload register is 0, behaviour is as undefined-macro.
- Undefined: expiry always goes to EXPIRED, as described in Operation.

## Test plan
- Reset: with WIDTH=8 and PRESCALE=4, hold `reset_n`=0 mid-RUN → `count`=0, `done`=0, `running`=0 immediately, with no clock required.
- Basic countdown: `load`=3 then `start` at E0 → `tick` at E0+4, E0+8, E0+12; `count` 2,1,0; `done`=1 at E0+12; `ack` → IDLE, `done`=0.
- Pause/resume: `load`=5, `start`, `pause` 2 cycles after start, hold 10 cycles, then `start` → next tick 2 cycles after resume; total expiry at 20 RUN cycles.
- Zero and priority:
  - `load`=0 then `start` → EXPIRED next edge.
  - `load` coinciding with a tick → `count`=`load_value`, `tick`=0, IDLE.
  - `pause` on the final tick → EXPIRED, not PAUSED.
- Auto-reload (macro defined): `load`=2, `start` → `count` 1,2,1,2… every 4 cycles; `done` set at the first wrap and cleared by `ack` while `running` stays 1.
